// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port integer register file with a per-register
// busy scoreboard and a clear sequencer that zeroes one entry per cycle after reset.
// Optional build macro: REGFILE_BYPASS_EN (write-through bypass of wd and busy on
// a same-cycle write to a register being read).
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NRD*$clog2(NREGS)-1:0]     ra,
    output logic [NRD*XLEN-1:0]              rd,
    output logic [NRD-1:0]                   rd_busy,
    input  logic [$clog2(NREGS)-1:0]         wa,
    input  logic [XLEN-1:0]                  wd,
    input  logic                             wen,
    input  logic                             set_busy,
    input  logic [$clog2(NREGS)-1:0]         busy_addr,
    output logic                             ready
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;

    logic write_ok_c;
    logic set_ok_c;

    // Register 0 is hard-wired when ZERO_REG is set: writes and busy marks are dropped
    assign write_ok_c = wen && !((ZERO_REG != 0) && (wa == '0));
    assign set_ok_c   = set_busy && !((ZERO_REG != 0) && (busy_addr == '0));

    // Clear sequencer: walk idx over every entry after reset, then open for traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    idx <= idx + AW'(1);
                    if (idx == LAST_IDX) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state <= CLEAR;
                    idx   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset so it can map to distributed RAM; the sequencer zeroes it
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[idx] <= '0;
            end else if (ready && write_ok_c) begin
                regs[wa] <= wd;
            end
        end
    end

    // Scoreboard: writeback clears, issue sets; set is applied last so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (ready) begin
            if (wen) begin
                busy[wa] <= 1'b0;
            end
            if (set_ok_c) begin
                busy[busy_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr_c;
        logic [XLEN-1:0] data_c;
        logic            bsy_c;

        assign addr_c = ra[i*AW +: AW];

        // Combinational read port with zero-register masking and optional bypass
        always_comb begin
            data_c = regs[addr_c];
            bsy_c  = busy[addr_c];
            if ((ZERO_REG != 0) && (addr_c == '0)) begin
                data_c = '0;
                bsy_c  = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            if (write_ok_c && (wa == addr_c)) begin
                data_c = wd;
                bsy_c  = 1'b0;
            end
`endif
            if (!ready) begin
                data_c = '0;
                bsy_c  = 1'b0;
            end
        end

        assign rd[i*XLEN +: XLEN] = data_c;
        assign rd_busy[i]         = bsy_c;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a default instance (32 regs, 2 ports, zero reg)
// and a swept instance (16 regs, 3 ports, ordinary x0), both checked every cycle
// against an array/counter model of the register file.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        wen       [2];
    logic        set_busy  [2];
    logic [31:0] wd        [2];
    logic [4:0]  wa        [2];
    logic [4:0]  busy_addr [2];
    logic [4:0]  ra        [2][3];

    logic [63:0] rd0;
    logic [1:0]  rdb0;
    logic        ready0;
    logic [95:0] rd1;
    logic [2:0]  rdb1;
    logic        ready1;

    regfile_scoreboard u_dut0 (
        .clk       (clk),
        .rst       (rst[0]),
        .ra        ({ra[0][1], ra[0][0]}),
        .rd        (rd0),
        .rd_busy   (rdb0),
        .wa        (wa[0]),
        .wd        (wd[0]),
        .wen       (wen[0]),
        .set_busy  (set_busy[0]),
        .busy_addr (busy_addr[0]),
        .ready     (ready0)
    );

    regfile_scoreboard #(.NREGS(16), .NRD(3), .ZERO_REG(0)) u_dut1 (
        .clk       (clk),
        .rst       (rst[1]),
        .ra        ({ra[1][2][3:0], ra[1][1][3:0], ra[1][0][3:0]}),
        .rd        (rd1),
        .rd_busy   (rdb1),
        .wa        (wa[1][3:0]),
        .wd        (wd[1]),
        .wen       (wen[1]),
        .set_busy  (set_busy[1]),
        .busy_addr (busy_addr[1][3:0]),
        .ready     (ready1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [31:0] m_mem   [2][32];
    bit          m_busy  [2][32];
    bit          m_ready [2];
    int          m_cnt   [2];
    bit          chk_en  [2];

    function automatic int nregs_of(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic int nrd_of(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic bit zero_of(input int k);
        return (k == 0);
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input int p);
        int a;
        a = int'(ra[k][p]);
        if (!m_ready[k]) return 32'h0;
        if (zero_of(k) && a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wen[k] && int'(wa[k]) == a) return wd[k];
`endif
        return m_mem[k][a];
    endfunction

    function automatic logic exp_busy(input int k, input int p);
        int a;
        a = int'(ra[k][p]);
        if (!m_ready[k]) return 1'b0;
        if (zero_of(k) && a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wen[k] && int'(wa[k]) == a) return 1'b0;
`endif
        return m_busy[k][a];
    endfunction

    function automatic logic [31:0] act_rd(input int k, input int p);
        if (k == 0) return 32'(rd0 >> (p * 32));
        return 32'(rd1 >> (p * 32));
    endfunction

    function automatic logic act_busy(input int k, input int p);
        if (k == 0) return 1'(rdb0 >> p);
        return 1'(rdb1 >> p);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update on each rising edge from the spec's rules
    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst[k]) begin
                    m_ready[k] = 1'b0;
                    m_cnt[k]   = 0;
                    chk_en[k]  = 1'b1;
                    for (int r = 0; r < 32; r++) m_busy[k][r] = 1'b0;
                end else if (!m_ready[k]) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == nregs_of(k)) begin
                        m_ready[k] = 1'b1;
                        for (int r = 0; r < 32; r++) m_mem[k][r] = 32'h0;
                    end
                end else begin
                    if (wen[k] && !(zero_of(k) && wa[k] == 5'd0)) m_mem[k][wa[k]] = wd[k];
                    if (wen[k]) m_busy[k][wa[k]] = 1'b0;
                    if (set_busy[k] && !(zero_of(k) && busy_addr[k] == 5'd0))
                        m_busy[k][busy_addr[k]] = 1'b1;
                end
            end
        end
    end

    // Every-cycle compare of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (chk_en[k]) begin
                    chk($sformatf("ready%0d", k), 32'(k == 0 ? ready0 : ready1), 32'(m_ready[k]));
                    for (int p = 0; p < nrd_of(k); p++) begin
                        chk($sformatf("rd%0d_%0d", k, p), act_rd(k, p), exp_rd(k, p));
                        chk($sformatf("busy%0d_%0d", k, p), 32'(act_busy(k, p)), 32'(exp_busy(k, p)));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n1;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; wen[k] = 1'b0; set_busy[k] = 1'b0;
            wd[k] = 32'h0; wa[k] = 5'd0; busy_addr[k] = 5'd0;
            for (int p = 0; p < 3; p++) ra[k][p] = 5'd0;
        end
        tick();
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Clear latency on both parameterisations
        n0 = 0; n1 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready0 && n0 == 0) n0 = i;
            if (ready1 && n1 == 0) n1 = i;
        end
        chk("clear_lat0", 32'(n0), 32'd32);
        chk("clear_lat1", 32'(n1), 32'd16);

        // All entries read zero after clear
        for (int r = 0; r < 32; r++) begin
            ra[0][0] = 5'(r);
            ra[0][1] = 5'(31 - r);
            ra[1][0] = 5'(r % 16);
            ra[1][1] = 5'(15 - (r % 16));
            ra[1][2] = 5'((r + 3) % 16);
            #2;
            if (r == 17) chk("clr_x17", rd0[31:0], 32'h0);
            tick();
        end

        // Basic write/read on both ports
        wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; wen[0] = 1'b1;
        ra[0][0] = 5'd5; ra[0][1] = 5'd5;
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("wr_same_x5", rd0[31:0], 32'hDEADBEEF);
`else
        chk("wr_same_x5", rd0[31:0], 32'h0);
`endif
        tick();
        wen[0] = 1'b0;
        #2;
        chk("x5_p0", rd0[31:0], 32'hDEADBEEF);
        chk("x5_p1", rd0[63:32], 32'hDEADBEEF);

        // x0 ignores writes and busy marks
        wa[0] = 5'd0; wd[0] = 32'h1234; wen[0] = 1'b1;
        set_busy[0] = 1'b1; busy_addr[0] = 5'd0;
        tick();
        wen[0] = 1'b0; set_busy[0] = 1'b0; ra[0][0] = 5'd0;
        #2;
        chk("x0_zero", rd0[31:0], 32'h0);
        chk("x0_notbusy", 32'(rdb0[0]), 32'h0);

        // Scoreboard set, clear, and set-wins
        set_busy[0] = 1'b1; busy_addr[0] = 5'd7; ra[0][0] = 5'd7;
        tick();
        set_busy[0] = 1'b0;
        #2;
        chk("busy7_set", 32'(rdb0[0]), 32'h1);
        wen[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h55;
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("busy7_byp", 32'(rdb0[0]), 32'h0);
`else
        chk("busy7_hold", 32'(rdb0[0]), 32'h1);
`endif
        tick();
        wen[0] = 1'b0;
        #2;
        chk("busy7_clr", 32'(rdb0[0]), 32'h0);
        chk("x7_55", rd0[31:0], 32'h55);
        set_busy[0] = 1'b1; busy_addr[0] = 5'd7;
        wen[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h66;
        tick();
        set_busy[0] = 1'b0; wen[0] = 1'b0;
        #2;
        chk("busy7_setwins", 32'(rdb0[0]), 32'h1);
        chk("x7_66", rd0[31:0], 32'h66);

        // Same-cycle write/read of x3
        ra[0][0] = 5'd3; wa[0] = 5'd3; wd[0] = 32'hA5A5A5A5; wen[0] = 1'b1;
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("x3_same", rd0[31:0], 32'hA5A5A5A5);
`else
        chk("x3_same", rd0[31:0], 32'h0);
`endif
        tick();
        wen[0] = 1'b0;
        #2;
        chk("x3_next", rd0[31:0], 32'hA5A5A5A5);

        // Swept instance: x0 writable/busy, three distinct ports
        wen[1] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wa[1] = 5'(r);
            wd[1] = 32'(32'h11 * (r + 1));
            tick();
        end
        wen[1] = 1'b0;
        set_busy[1] = 1'b1; busy_addr[1] = 5'd0;
        tick();
        set_busy[1] = 1'b0;
        ra[1][0] = 5'd0; ra[1][1] = 5'd1; ra[1][2] = 5'd2;
        #2;
        chk("s_x0", rd1[31:0], 32'h11);
        chk("s_x1", rd1[63:32], 32'h22);
        chk("s_x2", rd1[95:64], 32'h33);
        chk("s_busy0", 32'(rdb1[0]), 32'h1);
        chk("s_busy1", 32'(rdb1[1]), 32'h0);

        // Mixed traffic on both instances
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < 2; k++) begin
                wen[k]       = (i % 3) != 0;
                wa[k]        = 5'((i * 7) % nregs_of(k));
                wd[k]        = 32'((i * 32'h01010101) ^ 32'hC3);
                set_busy[k]  = (i % 4) == 1;
                busy_addr[k] = 5'((i * 5 + 3) % nregs_of(k));
                for (int p = 0; p < 3; p++) ra[k][p] = 5'((i * 3 + p * 11) % nregs_of(k));
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            wen[k] = 1'b0; set_busy[k] = 1'b0;
        end

        // Reset part-way through clear, with traffic during the clear
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        repeat (10) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        wen[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'hFFFF;
        set_busy[0] = 1'b1; busy_addr[0] = 5'd9; ra[0][0] = 5'd9;
        n0 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready0 && n0 == 0) begin
                n0 = i;
                wen[0] = 1'b0;
                set_busy[0] = 1'b0;
            end
        end
        wen[0] = 1'b0; set_busy[0] = 1'b0;
        chk("reclear_lat", 32'(n0), 32'd32);
        #2;
        chk("x9_cleared", rd0[31:0], 32'h0);
        chk("x9_notbusy", 32'(rdb0[0]), 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
